// File: rtl/debug_unit.sv
// Debug/control unit: gates the multi-cycle CPU (run/step/halt), walks the
// debug read address with board buttons and muxes CPU status onto disp/led.
module debug_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              succ,
  input  logic              step,
  input  logic              inc,
  input  logic              dec,
  input  logic              m_rf,
  input  logic [2:0]        sel,
  input  logic              instr_done,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mdr,
  input  logic [15:0]       ctrl_word,
  output logic              run,
  output logic [ADDR_W-1:0] m_rf_addr,
  output logic [DATA_W-1:0] disp,
  output logic [15:0]       led,
  output logic [15:0]       inst_cnt,
  output logic [15:0]       cyc_cnt
);

  localparam int unsigned RF_AW = 5;
  localparam int unsigned BTN_W = 3;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    CONT = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [BTN_W-1:0]  btn_r1;
  logic [BTN_W-1:0]  btn_r2;
  logic [BTN_W-1:0]  btn_edge;
  logic              step_edge;
  logic              inc_only;
  logic              dec_only;
  logic [RF_AW-1:0]  rf_addr;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] disp_d;
  logic [15:0]       led_d;

  // Button synchronisers; bit order {dec, inc, step}
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_r1 <= '0;
      btn_r2 <= '0;
    end else begin
      btn_r1 <= {dec, inc, step};
      btn_r2 <= btn_r1;
    end
  end

  assign btn_edge  = btn_r1 & ~btn_r2;
  assign step_edge = btn_edge[0];
  assign inc_only  = btn_edge[1] & ~btn_edge[2];
  assign dec_only  = btn_edge[2] & ~btn_edge[1];

  // Run-mode next state; leaving CONT goes through STEP so the CPU halts on a boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (succ)           state_d = CONT;
        else if (step_edge) state_d = STEP;
      end
      STEP: begin
        if (succ)                   state_d = CONT;
        else if (run && instr_done) state_d = IDLE;
      end
      CONT: begin
        if (!succ) state_d = (run && instr_done) ? IDLE : STEP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next debug address; the register-file view wraps at 32 and clears upper bits
  always_comb begin
    addr_d  = m_rf_addr;
    rf_addr = m_rf_addr[RF_AW-1:0];
    if (m_rf) begin
      if (inc_only)      rf_addr = rf_addr + RF_AW'(1);
      else if (dec_only) rf_addr = rf_addr - RF_AW'(1);
      addr_d = ADDR_W'(rf_addr);
    end else begin
      if (inc_only)      addr_d = m_rf_addr + ADDR_W'(1);
      else if (dec_only) addr_d = m_rf_addr - ADDR_W'(1);
    end
  end

  // Display and LED source selection
  always_comb begin
    disp_d = mdr;
    case (sel)
      3'd0:    disp_d = m_rf ? rf_data : mem_data;
      3'd1:    disp_d = pc;
      3'd2:    disp_d = npc;
      3'd3:    disp_d = ir;
      3'd4:    disp_d = rs_val;
      3'd5:    disp_d = rt_val;
      3'd6:    disp_d = alu_out;
      default: disp_d = mdr;
    endcase
    led_d = (sel == 3'd0) ? 16'(m_rf_addr) : ctrl_word;
  end

  // State, run enable, counters and registered views
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      run       <= 1'b0;
      m_rf_addr <= '0;
      disp      <= '0;
      led       <= '0;
      inst_cnt  <= '0;
      cyc_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      run       <= (state_d != IDLE);
      m_rf_addr <= addr_d;
      disp      <= disp_d;
      led       <= led_d;
      if (run) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
        if (instr_done) inst_cnt <= inst_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Directed self-checking bench for debug_unit with a 4-cycle CPU model.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        succ = 1'b0;
  logic        step = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        m_rf = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        instr_done;
  logic [31:0] rf_data = '0;
  logic [31:0] mem_data = '0;
  logic [31:0] pc = '0;
  logic [31:0] npc = '0;
  logic [31:0] ir = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] mdr = '0;
  logic [15:0] ctrl_word = '0;
  logic        run;
  logic [7:0]  m_rf_addr;
  logic [31:0] disp;
  logic [15:0] led;
  logic [15:0] inst_cnt;
  logic [15:0] cyc_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  phase;
  logic [31:0] vals [8];

  debug_unit dut (
    .clk(clk), .rst(rst), .succ(succ), .step(step), .inc(inc), .dec(dec),
    .m_rf(m_rf), .sel(sel), .instr_done(instr_done), .rf_data(rf_data),
    .mem_data(mem_data), .pc(pc), .npc(npc), .ir(ir), .rs_val(rs_val),
    .rt_val(rt_val), .alu_out(alu_out), .mdr(mdr), .ctrl_word(ctrl_word),
    .run(run), .m_rf_addr(m_rf_addr), .disp(disp), .led(led),
    .inst_cnt(inst_cnt), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  // CPU model: every instruction takes four enabled cycles
  always @(posedge clk) begin
    if (!rst)     phase <= 2'd0;
    else if (run) phase <= phase + 2'd1;
  end
  assign instr_done = run && (phase == 2'd3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic i, input logic d);
    inc = i; dec = d;
    tick(); tick();
    inc = 1'b0; dec = 1'b0;
    tick(); tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int runs;
    vals[0] = 32'h0;
    vals[1] = 32'h0040_0010; vals[2] = 32'h0040_0014; vals[3] = 32'h8C08_0004;
    vals[4] = 32'h1111_2222; vals[5] = 32'h3333_4444; vals[6] = 32'h5555_6666;
    vals[7] = 32'h7777_8888;

    // Reset state
    do_reset();
    check("rst_run", 32'(run), 32'd0);
    check("rst_addr", 32'(m_rf_addr), 32'd0);
    check("rst_disp", disp, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_inst", 32'(inst_cnt), 32'd0);
    check("rst_cyc", 32'(cyc_cnt), 32'd0);

    // Reset in the middle of continuous run
    succ = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("cont_run", 32'(run), 32'd1);
    check("cont_cyc", 32'(cyc_cnt), 32'd9);
    check("cont_inst", 32'(inst_cnt), 32'd2);
    rst = 1'b0;
    tick();
    check("midrst_run", 32'(run), 32'd0);
    check("midrst_cyc", 32'(cyc_cnt), 32'd0);
    check("midrst_inst", 32'(inst_cnt), 32'd0);
    rst = 1'b1;
    tick();
    check("rerun_run", 32'(run), 32'd1);
    check("rerun_cyc", 32'(cyc_cnt), 32'd0);
    succ = 1'b0;
    n = 0;
    while (run && n < 20) begin tick(); n++; end
    check("rerun_halt", 32'(run), 32'd0);
    do_reset();

    // Single step with the button held for 20 cycles
    step = 1'b1;
    runs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (run) runs++;
    end
    step = 1'b0;
    check("step_runs", 32'(runs), 32'd4);
    check("step_inst", 32'(inst_cnt), 32'd1);
    check("step_cyc", 32'(cyc_cnt), 32'd4);
    check("step_idle", 32'(run), 32'd0);
    tick(); tick();
    do_reset();

    // Continuous run released mid-instruction stops on the boundary
    succ = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    succ = 1'b0;
    tick();
    check("stop_still_run", 32'(run), 32'd1);
    n = 1;
    while (run && n < 20) begin tick(); n++; end
    check("stop_ticks", 32'(n), 32'd2);
    check("stop_cyc", 32'(cyc_cnt), 32'd8);
    check("stop_inst", 32'(inst_cnt), 32'd2);
    do_reset();

    // Address wrap in both views and simultaneous inc/dec
    m_rf = 1'b0;
    press(1'b0, 1'b1);
    check("mem_dec_wrap", 32'(m_rf_addr), 32'h0000_00FF);
    press(1'b1, 1'b0);
    check("mem_inc_wrap", 32'(m_rf_addr), 32'h0000_0000);
    m_rf = 1'b1;
    press(1'b0, 1'b1);
    check("rf_dec_wrap", 32'(m_rf_addr), 32'd31);
    press(1'b1, 1'b0);
    check("rf_inc_wrap", 32'(m_rf_addr), 32'd0);
    press(1'b1, 1'b1);
    check("both_pressed", 32'(m_rf_addr), 32'd0);

    // View switch truncates the address; register data shown on disp
    m_rf = 1'b0;
    for (int i = 0; i < 42; i++) press(1'b1, 1'b0);
    check("addr_2a", 32'(m_rf_addr), 32'h0000_002A);
    sel = 3'd0; rf_data = 32'hDEAD_BEEF; mem_data = 32'h1234_5678;
    tick();
    check("disp_mem", disp, 32'h1234_5678);
    check("led_addr_mem", 32'(led), 32'h0000_002A);
    m_rf = 1'b1;
    tick();
    check("addr_trunc", 32'(m_rf_addr), 32'h0000_000A);
    check("disp_rf", disp, 32'hDEAD_BEEF);
    tick();
    check("led_addr_rf", 32'(led), 32'h0000_000A);

    // Display mux sweep over CPU status words
    pc = vals[1]; npc = vals[2]; ir = vals[3]; rs_val = vals[4];
    rt_val = vals[5]; alu_out = vals[6]; mdr = vals[7];
    ctrl_word = 16'hA5C3;
    for (int s = 1; s < 8; s++) begin
      sel = 3'(s);
      tick();
      check($sformatf("disp_sel%0d", s), disp, vals[s]);
      check($sformatf("led_sel%0d", s), 32'(led), 32'h0000_A5C3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
